sram_arbiter: RTL and testbench

Shares the single 20-bit-address, 16-bit-wide external SRAM between three requesters: the VGA pixel fetcher, the background loader (which streams background images into SRAM) and the game/trail writer. The arbiter sits between those masters and the SRAM pins. It grants one access at a time, drives the active-low SRAM strobes, and returns a one-cycle acknowledge with read data. VGA has priority but is burst-limited so background loading and trail updates cannot starve.

---
 rtl/sram_arbiter_pkg.sv | 26 ++
 rtl/sram_arbiter_if.sv | 61 ++++++
 rtl/sram_arbiter_pick.sv | 44 ++++
 rtl/sram_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and default widths for the SRAM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

    localparam int ADDR_W_DEF        = 20;
    localparam int DATA_W_DEF        = 16;
    localparam int VGA_BURST_MAX_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_VGA  = 2'd0,
        REQ_BG   = 2'd1,
        REQ_GAME = 2'd2
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_if
//  Description : Requester handshakes plus SRAM pin bundle of the arbiter.
//                master = requesters and SRAM device side, slave = arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;

    logic              bg_req;
    logic              bg_we;
    logic [ADDR_W-1:0] bg_addr;
    logic [DATA_W-1:0] bg_wdata;
    logic              bg_ack;

    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_ack;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ub_n;
    logic              sram_lb_n;

    modport master (
        output vga_req, vga_addr,
        output bg_req, bg_we, bg_addr, bg_wdata,
        output game_req, game_we, game_addr, game_wdata,
        output sram_dq_in,
        input  vga_ack, bg_ack, game_ack, rdata, busy,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport slave (
        input  vga_req, vga_addr,
        input  bg_req, bg_we, bg_addr, bg_wdata,
        input  game_req, game_we, game_addr, game_wdata,
        input  sram_dq_in,
        output vga_ack, bg_ack, game_ack, rdata, busy,
        output sram_addr, sram_dq_out, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pick
//  Description : Combinational winner selection. VGA first unless its burst
//                budget is spent while another requester waits; Bg/Game
//                share by a round-robin pointer.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int VGA_BURST_MAX = 8,
    parameter int CNT_W         = 4
) (
    input  logic             vga_req,
    input  logic             bg_req,
    input  logic             game_req,
    input  logic [CNT_W-1:0] vga_cnt,
    input  logic             rr_favor_game,
    output req_id_t          win_id,
    output logic             win_valid
);

    logic vga_capped;

    assign vga_capped = (vga_cnt == CNT_W'(VGA_BURST_MAX)) && (bg_req || game_req);

    // Priority decision; VGA yields only when its burst budget is exhausted
    always_comb begin
        win_id    = REQ_VGA;
        win_valid = vga_req || bg_req || game_req;
        if (vga_req && !vga_capped) begin
            win_id = REQ_VGA;
        end else if (bg_req && game_req) begin
            win_id = rr_favor_game ? REQ_GAME : REQ_BG;
        end else if (bg_req) begin
            win_id = REQ_BG;
        end else if (game_req) begin
            win_id = REQ_GAME;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Three-master arbiter for a 16-bit asynchronous SRAM. Two
//                cycles per access (ACCESS, FINISH); all SRAM pins and acks
//                are registered from the latched request.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int VGA_BURST_MAX = VGA_BURST_MAX_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    sram_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(VGA_BURST_MAX + 1);

    arb_state_t        state;
    req_id_t           cur_id;
    logic              cur_we;
    logic [CNT_W-1:0]  vga_cnt;
    logic              rr_favor_game;

    req_id_t           win_id;
    logic              win_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;

    sram_arb_pick #(
        .VGA_BURST_MAX (VGA_BURST_MAX),
        .CNT_W         (CNT_W)
    ) u_pick (
        .vga_req       (bus.vga_req),
        .bg_req        (bus.bg_req),
        .game_req      (bus.game_req),
        .vga_cnt       (vga_cnt),
        .rr_favor_game (rr_favor_game),
        .win_id        (win_id),
        .win_valid     (win_valid)
    );

    // Route the winning requester's fields to the latch inputs
    always_comb begin
        sel_addr  = bus.vga_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
        case (win_id)
            REQ_BG: begin
                sel_addr  = bus.bg_addr;
                sel_we    = bus.bg_we;
                sel_wdata = bus.bg_wdata;
            end
            REQ_GAME: begin
                sel_addr  = bus.game_addr;
                sel_we    = bus.game_we;
                sel_wdata = bus.game_wdata;
            end
            default: ;
        endcase
    end

    // Access FSM with registered strobes, acks, read data and grant bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cur_id          <= REQ_VGA;
            cur_we          <= 1'b0;
            vga_cnt         <= '0;
            rr_favor_game   <= 1'b0;
            bus.vga_ack     <= 1'b0;
            bus.bg_ack      <= 1'b0;
            bus.game_ack    <= 1'b0;
            bus.rdata       <= '0;
            bus.busy        <= 1'b0;
            bus.sram_addr   <= '0;
            bus.sram_dq_out <= '0;
            bus.sram_dq_oe  <= 1'b0;
            bus.sram_ce_n   <= 1'b1;
            bus.sram_oe_n   <= 1'b1;
            bus.sram_we_n   <= 1'b1;
            bus.sram_ub_n   <= 1'b1;
            bus.sram_lb_n   <= 1'b1;
        end else begin
            bus.vga_ack  <= 1'b0;
            bus.bg_ack   <= 1'b0;
            bus.game_ack <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (win_valid) begin
                        state           <= ACCESS;
                        cur_id          <= win_id;
                        cur_we          <= sel_we;
                        bus.busy        <= 1'b1;
                        bus.sram_addr   <= sel_addr;
                        bus.sram_dq_out <= sel_wdata;
                        bus.sram_dq_oe  <= sel_we;
                        bus.sram_ce_n   <= 1'b0;
                        bus.sram_ub_n   <= 1'b0;
                        bus.sram_lb_n   <= 1'b0;
                        bus.sram_oe_n   <= sel_we;
                        bus.sram_we_n   <= ~sel_we;
                        if (win_id == REQ_VGA) begin
                            if (vga_cnt != CNT_W'(VGA_BURST_MAX))
                                vga_cnt <= vga_cnt + CNT_W'(1);
                        end else begin
                            vga_cnt       <= '0;
                            rr_favor_game <= (win_id == REQ_BG);
                        end
                    end else begin
                        state          <= IDLE;
                        bus.busy       <= 1'b0;
                        bus.sram_dq_oe <= 1'b0;
                        bus.sram_ce_n  <= 1'b1;
                        bus.sram_ub_n  <= 1'b1;
                        bus.sram_lb_n  <= 1'b1;
                        bus.sram_oe_n  <= 1'b1;
                        bus.sram_we_n  <= 1'b1;
                    end
                    // A decision taken without VGA asking ends its burst
                    if (!bus.vga_req)
                        vga_cnt <= '0;
                end
                ACCESS: begin
                    // CE, address and write data stay put through FINISH for hold time
                    state         <= FINISH;
                    bus.sram_oe_n <= 1'b1;
                    bus.sram_we_n <= 1'b1;
                    if (!cur_we)
                        bus.rdata <= bus.sram_dq_in;
                    case (cur_id)
                        REQ_BG:   bus.bg_ack   <= 1'b1;
                        REQ_GAME: bus.game_ack <= 1'b1;
                        default:  bus.vga_ack  <= 1'b1;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Self-checking bench: directed scenarios plus random traffic
//                against a transaction-level memory/fairness reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int BURST  = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic init_mem = 1'b0;

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sram_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .VGA_BURST_MAX (BURST)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Behavioural asynchronous SRAM (256 words, address aliased on low byte)
    logic [15:0] sram_mem [256];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= 16'(i * 37 + 5);
        end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
            sram_mem[bus.sram_addr[7:0]] <= bus.sram_dq_out;
        end
    end
    assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_addr[7:0]] : 16'h0000;

    // Reference state: memory contents in completion order, last read value
    logic [15:0] ref_mem [256];
    logic [15:0] last_rd;
    int n_checks = 0;
    int n_errors = 0;

    // Random-traffic requester state: 0 = VGA, 1 = Bg, 2 = Game
    logic        act    [3];
    logic [19:0] t_addr [3];
    logic        t_we   [3];
    logic [15:0] t_data [3];
    int          wait_c [3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.vga_req    = 1'b0; bus.vga_addr  = '0;
        bus.bg_req     = 1'b0; bus.bg_we     = 1'b0; bus.bg_addr   = '0; bus.bg_wdata   = '0;
        bus.game_req   = 1'b0; bus.game_we   = 1'b0; bus.game_addr = '0; bus.game_wdata = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_all();
        repeat (2) tick();
        reset_n = 1'b1;
        last_rd = 16'h0000;
        tick();
    endtask

    task automatic new_txn(input int i);
        act[i]    = 1'b1;
        t_addr[i] = 20'($urandom_range(0, 255));
        t_we[i]   = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        t_data[i] = 16'($urandom);
        wait_c[i] = 0;
    endtask

    task automatic drive_all();
        bus.vga_req    = act[0]; bus.vga_addr  = t_addr[0];
        bus.bg_req     = act[1]; bus.bg_we     = t_we[1]; bus.bg_addr   = t_addr[1]; bus.bg_wdata   = t_data[1];
        bus.game_req   = act[2]; bus.game_we   = t_we[2]; bus.game_addr = t_addr[2]; bus.game_wdata = t_data[2];
    endtask

    initial begin
        int seq [$];
        logic [2:0] acks;
        logic [15:0] d;
        bit done;

        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 37 + 5);
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0; t_addr[i] = '0; t_we[i] = 1'b0; t_data[i] = '0; wait_c[i] = 0;
        end
        last_rd = 16'h0000;
        idle_all();
        init_mem = 1'b1;
        repeat (2) tick();
        init_mem = 1'b0;

        // ---- reset values ----
        check_val("rst_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 5'b11111);
        check_val("rst_dq_oe", bus.sram_dq_oe, 0);
        check_val("rst_acks", {bus.game_ack, bus.bg_ack, bus.vga_ack}, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_addr", bus.sram_addr, 0);
        check_val("rst_rdata", bus.rdata, 0);
        reset_n = 1'b1;
        tick();

        // ---- reset asserted mid-write ----
        bus.bg_req = 1'b1; bus.bg_we = 1'b1; bus.bg_addr = 20'h00099; bus.bg_wdata = 16'h1234;
        tick();
        check_val("midrst_pre_we", bus.sram_we_n, 0);
        #2 reset_n = 1'b0;
        #1;
        check_val("midrst_we_n", bus.sram_we_n, 1);
        check_val("midrst_ce_n", bus.sram_ce_n, 1);
        check_val("midrst_dq_oe", bus.sram_dq_oe, 0);
        check_val("midrst_acks", {bus.game_ack, bus.bg_ack, bus.vga_ack}, 0);
        idle_all();
        tick();
        reset_n = 1'b1;
        tick();
        check_val("midrst_idle_busy", bus.busy, 0);
        check_val("midrst_idle_ce", bus.sram_ce_n, 1);

        // ---- single write then read ----
        bus.bg_req = 1'b1; bus.bg_we = 1'b1; bus.bg_addr = 20'h00123; bus.bg_wdata = 16'hBEEF;
        tick();
        check_val("wr_acc_we_n", bus.sram_we_n, 0);
        check_val("wr_acc_ce_n", bus.sram_ce_n, 0);
        check_val("wr_acc_dq_oe", bus.sram_dq_oe, 1);
        check_val("wr_acc_dq", bus.sram_dq_out, 16'hBEEF);
        check_val("wr_acc_addr", bus.sram_addr, 20'h00123);
        check_val("wr_acc_noack", bus.bg_ack, 0);
        tick();
        check_val("wr_ack", bus.bg_ack, 1);
        check_val("wr_fin_we_n", bus.sram_we_n, 1);
        check_val("wr_fin_ce_n", bus.sram_ce_n, 0);
        check_val("wr_fin_dq_oe", bus.sram_dq_oe, 1);
        ref_mem[8'h23] = 16'hBEEF;
        bus.bg_req = 1'b0;
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 20'h00123;
        tick();
        check_val("rd_acc_oe_n", bus.sram_oe_n, 0);
        check_val("rd_acc_noack", {bus.game_ack, bus.bg_ack}, 0);
        tick();
        check_val("rd_ack", bus.game_ack, 1);
        check_val("rd_data", bus.rdata, 16'hBEEF);
        last_rd = 16'hBEEF;
        bus.game_req = 1'b0;
        tick();
        check_val("rd_idle_busy", bus.busy, 0);
        check_val("rd_idle_ce", bus.sram_ce_n, 1);

        // ---- VGA latency and throughput ----
        bus.vga_req = 1'b1; bus.vga_addr = 20'd0;
        seq = {};
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_val("tp_ack", bus.vga_ack, (k % 2 == 0) ? 1 : 0);
            check_val("tp_busy", bus.busy, 1);
            if (bus.vga_ack) begin
                check_val("tp_rdata", bus.rdata, ref_mem[bus.vga_addr[7:0]]);
                last_rd = ref_mem[bus.vga_addr[7:0]];
                bus.vga_addr = bus.vga_addr + 20'd1;
                seq.push_back(0);
                if (seq.size() == 4) bus.vga_req = 1'b0;
            end
        end
        tick();
        check_val("tp_idle", bus.busy, 0);

        // ---- VGA burst limit against a waiting Bg read ----
        bus.vga_req = 1'b1; bus.vga_addr = 20'h10;
        bus.bg_req = 1'b1; bus.bg_we = 1'b0; bus.bg_addr = 20'h40;
        seq = {};
        for (int c = 0; c < 80 && seq.size() < 11; c++) begin
            tick();
            acks = {bus.game_ack, bus.bg_ack, bus.vga_ack};
            check_val("burst_one_ack", ($countones(acks) <= 1) ? 1 : 0, 1);
            if (bus.vga_ack) begin
                check_val("burst_vga_rdata", bus.rdata, ref_mem[bus.vga_addr[7:0]]);
                last_rd = ref_mem[bus.vga_addr[7:0]];
                bus.vga_addr = bus.vga_addr + 20'd1;
                seq.push_back(0);
            end
            if (bus.bg_ack) begin
                check_val("burst_bg_rdata", bus.rdata, ref_mem[8'h40]);
                last_rd = ref_mem[8'h40];
                bus.bg_req = 1'b0;
                seq.push_back(1);
            end
        end
        bus.vga_req = 1'b0; bus.bg_req = 1'b0;
        check_val("burst_count", seq.size(), 11);
        for (int i = 0; i < seq.size(); i++)
            check_val($sformatf("burst_order[%0d]", i), seq[i], (i == BURST) ? 1 : 0);
        for (int c = 0; c < 10 && bus.busy; c++) tick();

        // ---- Bg/Game round-robin from reset pointer ----
        do_reset();
        bus.bg_req = 1'b1; bus.bg_we = 1'b0; bus.bg_addr = 20'h50;
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 20'h60;
        seq = {};
        for (int c = 0; c < 40 && seq.size() < 4; c++) begin
            tick();
            acks = {bus.game_ack, bus.bg_ack, bus.vga_ack};
            check_val("rr_one_ack", ($countones(acks) <= 1) ? 1 : 0, 1);
            if (bus.bg_ack) begin
                check_val("rr_bg_rdata", bus.rdata, ref_mem[bus.bg_addr[7:0]]);
                bus.bg_addr = bus.bg_addr + 20'd1;
                seq.push_back(1);
            end
            if (bus.game_ack) begin
                check_val("rr_game_rdata", bus.rdata, ref_mem[bus.game_addr[7:0]]);
                last_rd = ref_mem[bus.game_addr[7:0]];
                bus.game_addr = bus.game_addr + 20'd1;
                seq.push_back(2);
            end
            if (seq.size() == 4) begin
                bus.bg_req = 1'b0; bus.game_req = 1'b0;
            end
        end
        bus.bg_req = 1'b0; bus.game_req = 1'b0;
        check_val("rr_count", seq.size(), 4);
        for (int i = 0; i < seq.size(); i++)
            check_val($sformatf("rr_order[%0d]", i), seq[i], (i % 2 == 0) ? 1 : 2);
        for (int c = 0; c < 10 && bus.busy; c++) tick();

        // ---- Game write withdrawn during ACCESS ----
        d = 16'($urandom);
        bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 20'h77; bus.game_wdata = d;
        tick();
        bus.game_req = 1'b0; bus.game_addr = 20'h78; bus.game_wdata = ~d;
        check_val("drop_we_n", bus.sram_we_n, 0);
        tick();
        check_val("drop_ack", bus.game_ack, 1);
        check_val("drop_addr_held", bus.sram_addr, 20'h77);
        check_val("drop_rdata_kept", bus.rdata, last_rd);
        ref_mem[8'h77] = d;
        tick();
        check_val("drop_idle", bus.busy, 0);
        check_val("drop_mem", sram_mem[8'h77], d);

        // ---- random traffic ----
        done = 1'b0;
        for (int c = 0; c < 2400 && !done; c++) begin
            tick();
            acks = {bus.game_ack, bus.bg_ack, bus.vga_ack};
            check_val("rnd_one_ack", ($countones(acks) <= 1) ? 1 : 0, 1);
            for (int i = 0; i < 3; i++) if (act[i]) wait_c[i]++;
            for (int i = 0; i < 3; i++) begin
                if (acks[i]) begin
                    check_val("rnd_ack_has_req", act[i], 1);
                    check_val($sformatf("rnd_wait_bound[%0d]", i), (wait_c[i] <= ((i == 0) ? 8 : 40)) ? 1 : 0, 1);
                    if (t_we[i]) begin
                        ref_mem[t_addr[i][7:0]] = t_data[i];
                        check_val("rnd_rdata_after_wr", bus.rdata, last_rd);
                    end else begin
                        check_val("rnd_rdata", bus.rdata, ref_mem[t_addr[i][7:0]]);
                        last_rd = ref_mem[t_addr[i][7:0]];
                    end
                    act[i] = 1'b0;
                    if (c < 2000 && $urandom_range(0, 1) == 1) new_txn(i);
                end else if (!act[i] && c < 2000 && $urandom_range(0, 3) == 0) begin
                    new_txn(i);
                end
                if (act[i] && wait_c[i] > 100) begin
                    check_val($sformatf("rnd_timeout[%0d]", i), wait_c[i], 0);
                    done = 1'b1;
                end
            end
            drive_all();
            if (c >= 2000 && !act[0] && !act[1] && !act[2]) done = 1'b1;
        end
        check_val("rnd_drained", {act[2], act[1], act[0]}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
